// File: rtl/bmult44_seq_ctrl_pkg.sv
`default_nettype none
//============================================================================
// Module : bmult_seq_pkg
// Desc   : Shared widths, FSM states and tag type for the 44x44 sequencer.
// Rev    : 1.0  initial release
//============================================================================
package bmult_seq_pkg;

    localparam int CHUNK_W = 22;
    localparam int OP_W    = 2 * CHUNK_W;
    localparam int PROD_W  = 4 * CHUNK_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic       live;
        logic [1:0] shift_sel;
    } pp_tag_t;

    // shift_sel 0 -> weight 0, 1 -> one chunk, 2/3 -> two chunks
    function automatic logic [PROD_W-1:0] pp_align(input logic [OP_W-1:0] p,
                                                   input logic [1:0]      sel);
        logic [PROD_W-1:0] w_ext;
        w_ext = PROD_W'(p);
        case (sel)
            2'd0:    return w_ext;
            2'd1:    return w_ext << CHUNK_W;
            default: return w_ext << (2 * CHUNK_W);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/bmult44_seq_ctrl_if.sv
`default_nettype none
//============================================================================
// Module : bmult44_seq_ctrl_if
// Desc   : Request, result and multiplier-side signals of the sequencer.
// Rev    : 1.0  initial release
//============================================================================
interface bmult44_seq_ctrl_if;
    import bmult_seq_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [OP_W-1:0]     in_a;
    logic [OP_W-1:0]     in_b;
    logic                out_valid;
    logic                out_ready;
    logic [PROD_W-1:0]   out_prod;
    logic                mul_vld;
    logic [CHUNK_W-1:0]  mul_a;
    logic [CHUNK_W-1:0]  mul_b;
    logic [OP_W-1:0]     mul_p;

    // slave: the sequencer itself
    modport slave (
        input  in_valid, in_a, in_b, out_ready, mul_p,
        output in_ready, out_valid, out_prod, mul_vld, mul_a, mul_b
    );

    modport master (
        output in_valid, in_a, in_b, out_ready, mul_p,
        input  in_ready, out_valid, out_prod, mul_vld, mul_a, mul_b
    );

endinterface
`default_nettype wire

// File: rtl/bmult44_seq_ctrl_tag_pipe.sv
`default_nettype none
//============================================================================
// Module : mult_tag_pipe
// Desc   : DEPTH-stage delay line of partial-product tags, aligned with mul_p.
// Rev    : 1.0  initial release
//============================================================================
module mult_tag_pipe
    import bmult_seq_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  pp_tag_t i_tag,
    output pp_tag_t o_tag,
    output logic    o_pending
);

    pp_tag_t r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
        end else begin
            r_stage[0] <= i_tag;
            for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
        end
    end

    assign o_tag = r_stage[DEPTH-1];

    // Live tags that will still be in flight after the output stage retires
    generate
        if (DEPTH > 1) begin : g_pending
            always_comb begin
                o_pending = 1'b0;
                for (int k = 0; k < DEPTH - 1; k++) o_pending = o_pending | r_stage[k].live;
            end
        end else begin : g_no_pending
            assign o_pending = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/bmult44_seq_ctrl.sv
`default_nettype none
//============================================================================
// Module : bmult44_seq_ctrl
// Desc   : 44x44 unsigned multiply via four 22x22 passes on a shared multiplier.
// Rev    : 1.0  initial release
//============================================================================
module bmult44_seq_ctrl
    import bmult_seq_pkg::*;
#(
    parameter int MUL_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    bmult44_seq_ctrl_if.slave bus
);

    seq_state_t          r_state;
    seq_state_t          w_next_state;
    logic [OP_W-1:0]     r_a;
    logic [OP_W-1:0]     r_b;
    logic [1:0]          r_idx;
    logic [PROD_W-1:0]   r_acc;
    pp_tag_t             w_issue_tag;
    pp_tag_t             w_ret_tag;
    logic                w_pending;
    logic                w_in_ready;
    logic                w_accept;
    logic [CHUNK_W-1:0]  w_mul_a;
    logic [CHUNK_W-1:0]  w_mul_b;

    assign w_in_ready = (r_state == IDLE) && !rst;
    assign w_accept   = w_in_ready && bus.in_valid;

    always_comb begin
        w_next_state = r_state;
        w_issue_tag  = '0;
        w_mul_a      = '0;
        w_mul_b      = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next_state = ISSUE;
            end
            ISSUE: begin
                // idx[1] picks the A half, idx[0] the B half
                w_issue_tag.live      = 1'b1;
                w_issue_tag.shift_sel = (r_idx == 2'd0) ? 2'd0 :
                                        (r_idx == 2'd3) ? 2'd2 : 2'd1;
                w_mul_a = r_idx[1] ? r_a[OP_W-1:CHUNK_W] : r_a[CHUNK_W-1:0];
                w_mul_b = r_idx[0] ? r_b[OP_W-1:CHUNK_W] : r_b[CHUNK_W-1:0];
                if (r_idx == 2'd3) w_next_state = DRAIN;
            end
            DRAIN: begin
                if (!w_pending) w_next_state = DONE;
            end
            DONE: begin
                if (bus.out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_a   <= bus.in_a;
                r_b   <= bus.in_b;
                r_idx <= '0;
                r_acc <= '0;
            end else begin
                if (r_state == ISSUE) r_idx <= r_idx + 2'd1;
                if (w_ret_tag.live)   r_acc <= r_acc + pp_align(bus.mul_p, w_ret_tag.shift_sel);
            end
        end
    end

    mult_tag_pipe #(
        .DEPTH (MUL_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .i_tag     (w_issue_tag),
        .o_tag     (w_ret_tag),
        .o_pending (w_pending)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == DONE);
    assign bus.out_prod  = (r_state == DONE) ? r_acc : '0;
    assign bus.mul_vld   = w_issue_tag.live;
    assign bus.mul_a     = w_mul_a;
    assign bus.mul_b     = w_mul_b;

endmodule
`default_nettype wire

// File: tb/tb_bmult44_seq_ctrl.sv
`default_nettype none
//============================================================================
// Module : tb_bmult44_seq_ctrl
// Desc   : Scoreboard bench for the sequencer at MUL_LAT=1 and MUL_LAT=2.
// Rev    : 1.0  initial release
//============================================================================
module tb_bmult44_seq_ctrl;
    import bmult_seq_pkg::*;

    localparam int N_RAND = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_acc1 = 0;
    int   n_acc2 = 0;

    logic [PROD_W-1:0] sb1 [$];
    logic [PROD_W-1:0] sb2 [$];
    logic [OP_W-1:0]   mul_log [$];
    logic [OP_W-1:0]   r_m1;
    logic [OP_W-1:0]   r_m2a;
    logic [OP_W-1:0]   r_m2b;

    bmult44_seq_ctrl_if if1 ();
    bmult44_seq_ctrl_if if2 ();

    bmult44_seq_ctrl #(.MUL_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    bmult44_seq_ctrl #(.MUL_LAT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        r_m1  <= OP_W'(if1.mul_a) * OP_W'(if1.mul_b);
        r_m2a <= OP_W'(if2.mul_a) * OP_W'(if2.mul_b);
        r_m2b <= r_m2a;
    end
    assign if1.mul_p = r_m1;
    assign if2.mul_p = r_m2b;

    task automatic chk(input string tag, input logic [PROD_W-1:0] got,
                       input logic [PROD_W-1:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OP_W-1:0] rand_op();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            default: return r[OP_W-1:0];
        endcase
    endfunction

    // Scoreboards: push on accept, pop on consume; reset discards pending work
    always @(negedge clk) begin
        if (rst) begin
            sb1.delete();
        end else begin
            if (if1.in_valid && if1.in_ready) begin
                sb1.push_back(PROD_W'(if1.in_a) * PROD_W'(if1.in_b));
                n_acc1++;
            end
            if (if1.out_valid && if1.out_ready) begin
                chk("dut1_sb_nonempty", PROD_W'(sb1.size() != 0), PROD_W'(1));
                if (sb1.size() != 0) chk("dut1_prod", if1.out_prod, sb1.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            sb2.delete();
        end else begin
            if (if2.in_valid && if2.in_ready) begin
                sb2.push_back(PROD_W'(if2.in_a) * PROD_W'(if2.in_b));
                n_acc2++;
            end
            if (if2.out_valid && if2.out_ready) begin
                chk("dut2_sb_nonempty", PROD_W'(sb2.size() != 0), PROD_W'(1));
                if (sb2.size() != 0) chk("dut2_prod", if2.out_prod, sb2.pop_front());
            end
        end
    end

    task automatic do_req(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                          output logic [PROD_W-1:0] prod, output int lat);
        int n;
        n = 0;
        while (!if1.in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("req_ready", PROD_W'(if1.in_ready), PROD_W'(1));
        if1.in_valid = 1'b1;
        if1.in_a     = a;
        if1.in_b     = b;
        tick();
        if1.in_valid = 1'b0;
        if1.in_a     = ~a;
        if1.in_b     = ~b;
        mul_log.delete();
        lat = 0;
        do begin
            if (if1.mul_vld) mul_log.push_back({if1.mul_a, if1.mul_b});
            tick();
            lat++;
        end while (!if1.out_valid && lat < 30);
        prod = if1.out_prod;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [PROD_W-1:0] prod;
        logic [PROD_W-1:0] exp_p;
        int                lat;
        int                hits;
        int                cyc;

        if1.in_valid = 1'b0; if1.in_a = '0; if1.in_b = '0; if1.out_ready = 1'b1;
        if2.in_valid = 1'b0; if2.in_a = '0; if2.in_b = '0; if2.out_ready = 1'b1;

        // Reset: outputs quiet, in_ready low, then high right after release
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i >= 1) begin
                chk("rst_ctrl", PROD_W'({if1.in_ready, if1.out_valid, if1.mul_vld,
                                         if1.mul_a, if1.mul_b}), PROD_W'(0));
                chk("rst_prod", if1.out_prod, PROD_W'(0));
            end
        end
        rst = 1'b0;
        #1;
        chk("rst_release_ready", PROD_W'(if1.in_ready), PROD_W'(1));
        chk("rst_release_valid", PROD_W'(if1.out_valid), PROD_W'(0));

        // Bit-22 operands: one product per half pair, 5-edge latency
        do_req(44'h00000400000, 44'h00000400000, prod, lat);
        chk("b22_lat", PROD_W'(lat), PROD_W'(5));
        chk("b22_prod", prod, 88'h0000000000100000000000);
        chk("b22_nmul", PROD_W'(mul_log.size()), PROD_W'(4));
        for (int k = 0; k < 4; k++)
            if (k < mul_log.size())
                chk("b22_mul_ab", PROD_W'(mul_log[k]),
                    PROD_W'({CHUNK_W'(k / 2), CHUNK_W'(k % 2)}));
        tick();

        // All-ones operands
        do_req('1, '1, prod, lat);
        chk("ones_lat", PROD_W'(lat), PROD_W'(5));
        chk("ones_prod", prod, 88'hFFFFFFFFFFE00000000001);
        tick();

        // Backpressure: result held, new requests ignored
        if1.out_ready = 1'b0;
        do_req(44'h123456789AB, 44'hFEDCBA98765, prod, lat);
        exp_p = PROD_W'(44'h123456789AB) * PROD_W'(44'hFEDCBA98765);
        for (int k = 0; k < 3; k++) begin
            if1.in_valid = 1'b1;
            if1.in_a     = OP_W'(k + 1);
            if1.in_b     = OP_W'(k + 2);
            #1;
            chk("hold_valid", PROD_W'(if1.out_valid), PROD_W'(1));
            chk("hold_prod", if1.out_prod, exp_p);
            chk("hold_ready", PROD_W'(if1.in_ready), PROD_W'(0));
            tick();
        end
        if1.in_valid  = 1'b0;
        if1.out_ready = 1'b1;
        tick();
        chk("release_ready", PROD_W'(if1.in_ready), PROD_W'(1));
        chk("release_valid", PROD_W'(if1.out_valid), PROD_W'(0));

        // Reset two cycles after accept discards the operation
        if1.in_valid = 1'b1; if1.in_a = 44'd7; if1.in_b = 44'd9;
        tick();
        if1.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hits = 0;
        for (int k = 0; k < 12; k++) begin
            if (if1.out_valid) hits++;
            tick();
        end
        chk("abort_no_valid", PROD_W'(hits), PROD_W'(0));
        do_req(44'd3, 44'd5, prod, lat);
        chk("abort_next_prod", prod, PROD_W'(15));
        chk("abort_next_lat", PROD_W'(lat), PROD_W'(5));
        tick();

        // Random back-to-back traffic on both latencies
        cyc = 0;
        n_acc1 = 0;
        n_acc2 = 0;
        while ((n_acc1 < N_RAND || n_acc2 < N_RAND) && cyc < 60000) begin
            if1.in_valid  = 1'b1;
            if1.in_a      = rand_op();
            if1.in_b      = rand_op();
            if1.out_ready = ($urandom_range(0, 3) != 0);
            if2.in_valid  = 1'b1;
            if2.in_a      = rand_op();
            if2.in_b      = rand_op();
            if2.out_ready = ($urandom_range(0, 3) != 0);
            tick();
            cyc++;
        end
        chk("rand_accepts", PROD_W'(n_acc1 >= N_RAND && n_acc2 >= N_RAND), PROD_W'(1));
        if1.in_valid = 1'b0; if1.out_ready = 1'b1;
        if2.in_valid = 1'b0; if2.out_ready = 1'b1;
        repeat (20) tick();
        chk("dut1_drained", PROD_W'(sb1.size()), PROD_W'(0));
        chk("dut2_drained", PROD_W'(sb2.size()), PROD_W'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
